branch_resolver: RTL

- Consumer end of the instruction-fetch interface: takes the 32-bit instruction word and halt flag from the fetch unit and produces the 7-bit redirect address (branchResultOut) that the fetch unit reads.
- Holds the compare flags and resolves conditional and unconditional branches.
- Squashes wrong-path instructions fetched after a redirect.
- Forwards valid instructions to the execute stage.

---
 rtl/branch_resolver_pkg.sv | 23 ++
 rtl/branch_resolver_if.sv | 26 ++
 rtl/branch_resolver_cond_eval.sv | 23 ++
 rtl/branch_resolver.sv | 125 ++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver and its condition evaluator.
package branch_pkg;

   localparam logic [4:0] OP_CMP  = 5'b01100;
   localparam logic [4:0] OP_B    = 5'b01101;
   localparam logic [4:0] OP_BEQ  = 5'b01110;
   localparam logic [4:0] OP_BNE  = 5'b01111;
   localparam logic [4:0] OP_BLT  = 5'b10000;
   localparam logic [4:0] OP_BGT  = 5'b10001;
   localparam logic [4:0] OP_HALT = 5'b01011;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } state_t;

   typedef struct packed {
      logic n;
      logic z;
   } flags_t;

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch-to-resolver bus: instruction/halt/operands in, redirect and execute-stage outputs back.
interface branch_resolver_if #(
   parameter int PC_W    = 7,
   parameter int INSTR_W = 32,
   parameter int DATA_W  = 32
);
   logic [INSTR_W-1:0] Instruccion;
   logic               Done;
   logic [DATA_W-1:0]  opA;
   logic [DATA_W-1:0]  opB;
   logic [PC_W-1:0]    branchResultOut;
   logic [INSTR_W-1:0] instr_o;
   logic               instr_valid_o;
   logic [1:0]         flags_o;
   logic               halted_o;

   modport master (
      output Instruccion, Done, opA, opB,
      input  branchResultOut, instr_o, instr_valid_o, flags_o, halted_o
   );

   modport slave (
      input  Instruccion, Done, opA, opB,
      output branchResultOut, instr_o, instr_valid_o, flags_o, halted_o
   );
endinterface

// File: rtl/branch_resolver_cond_eval.sv
// Combinational branch condition: opcode plus current flags -> taken.
module branch_cond_eval
   import branch_pkg::*;
(
   input  logic [4:0] i_opcode,
   input  flags_t     i_flags,
   output logic       o_taken
);

   // Non-branch opcodes (including CMP) never report taken.
   always_comb begin
      o_taken = 1'b0;
      case (i_opcode)
         OP_B:    o_taken = 1'b1;
         OP_BEQ:  o_taken = i_flags.z;
         OP_BNE:  o_taken = !i_flags.z;
         OP_BLT:  o_taken = i_flags.n;
         OP_BGT:  o_taken = !i_flags.n && !i_flags.z;
         default: o_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: holds compare flags, issues one-cycle redirects, squashes
// wrong-path words and forwards valid instructions to execute.
//
//   state | meaning
//   RUN   | forwarding words, resolving CMP and branches
//   FLUSH | squashing wrong-path words after a redirect, r_cnt left
//   HALT  | fetch reported halt; outputs quiet until reset
module branch_resolver
   import branch_pkg::*;
#(
   parameter int PC_W         = 7,
   parameter int INSTR_W      = 32,
   parameter int DATA_W       = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input logic              clk,
   input logic              rst,
   branch_resolver_if.slave bus
);

   localparam logic [1:0] LP_FLUSH = 2'(FLUSH_CYCLES);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [1:0]         r_cnt;
   logic [1:0]         w_cnt_nxt;
   logic [INSTR_W-1:0] r_instr;
   logic               r_valid;
   logic [PC_W-1:0]    r_br;
   flags_t             r_flags;

   logic [4:0]         w_opcode;
   logic [PC_W-1:0]    w_target;
   logic               w_taken;
   logic               w_fwd;
   logic               w_redirect;
   logic               w_flag_upd;
   flags_t             w_cmp;
   logic               w_unused;

   assign w_opcode = bus.Instruccion[INSTR_W-1:INSTR_W-5];
   assign w_target = bus.Instruccion[PC_W-1:0];
   // Middle instruction bits belong to the execute stage, not to branch decode.
   assign w_unused = ^bus.Instruccion[INSTR_W-6:PC_W];

   assign w_cmp.z = (bus.opA == bus.opB);
   assign w_cmp.n = ($signed(bus.opA) < $signed(bus.opB));

   branch_cond_eval u_cond (
      .i_opcode (w_opcode),
      .i_flags  (r_flags),
      .o_taken  (w_taken)
   );

   // State and squash counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RUN;
         r_cnt   <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state and per-cycle actions; Done overrides any branch or CMP.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_fwd       = 1'b0;
      w_redirect  = 1'b0;
      w_flag_upd  = 1'b0;
      case (r_state)
         RUN: begin
            if (bus.Done) begin
               w_state_nxt = HALT;
            end else begin
               w_fwd      = 1'b1;
               w_flag_upd = (w_opcode == OP_CMP);
               // Target 0 means "sequential" on the bus, so it cannot redirect.
               if (w_taken && (w_target != '0)) begin
                  w_redirect  = 1'b1;
                  w_state_nxt = FLUSH;
                  w_cnt_nxt   = LP_FLUSH;
               end
            end
         end
         FLUSH: begin
            if (bus.Done) begin
               w_state_nxt = HALT;
            end else begin
               w_cnt_nxt = r_cnt - 2'd1;
               if (r_cnt <= 2'd1) begin
                  w_state_nxt = RUN;
                  w_cnt_nxt   = 2'd0;
               end
            end
         end
         HALT:    w_state_nxt = HALT;
         default: w_state_nxt = RUN;
      endcase
   end

   // Registered outputs toward fetch and execute.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_instr <= '0;
         r_valid <= 1'b0;
         r_br    <= '0;
         r_flags <= '0;
      end else begin
         r_valid <= w_fwd;
         r_br    <= w_redirect ? w_target : '0;
         if (w_fwd)      r_instr <= bus.Instruccion;
         if (w_flag_upd) r_flags <= w_cmp;
      end
   end

   assign bus.branchResultOut = r_br;
   assign bus.instr_o         = r_instr;
   assign bus.instr_valid_o   = r_valid;
   assign bus.flags_o         = r_flags;
   assign bus.halted_o        = (r_state == HALT);

endmodule
